// File: rtl/img_pkg.sv
// Shared definitions for the sepia image pipeline: default widths, BMP row
// alignment, the packer state encoding and the 8-bit saturation helper.
package img_pkg;

  localparam int PIX_W          = 10;
  localparam int DIM_W          = 16;
  localparam int BMP_ROW_ALIGN  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EMIT_B = 3'd2,
    ST_EMIT_G = 3'd3,
    ST_EMIT_R = 3'd4,
    ST_PAD    = 3'd5,
    ST_FIN    = 3'd6
  } packer_state_t;

  function automatic logic [7:0] sat_byte(input logic [PIX_W-1:0] v);
    return (v > PIX_W'(255)) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/sat8.sv
// Combinational clamp of an unsigned PIX_W-bit channel value to one byte.
module sat8
  import img_pkg::*;
#(
  parameter int W = img_pkg::PIX_W
) (
  input  logic [W-1:0] d,
  output logic [7:0]   q
);

  localparam logic [W-1:0] MAX_BYTE = W'(255);

  assign q = (d > MAX_BYTE) ? 8'hFF : d[7:0];

endmodule

// File: rtl/bmp_pixel_packer.sv
// Serialises saturated RGB pixels into a BMP pixel-array byte stream
// (B,G,R per pixel, each row zero-padded to a 4-byte boundary).
module bmp_pixel_packer
  import img_pkg::*;
#(
  parameter int PIX_W = img_pkg::PIX_W,
  parameter int DIM_W = img_pkg::DIM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer never makes valid depend on ready; out_data/out_last are
  // held while out_valid is high and out_ready is low.

  localparam int ALIGN_W = $clog2(BMP_ROW_ALIGN);

  packer_state_t    state_q, state_d;
  logic [DIM_W-1:0] width_q, width_d;
  logic [DIM_W-1:0] height_q, height_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [ALIGN_W-1:0] pad_q, pad_d;
  logic [7:0]       r_q, g_q, b_q;
  logic [7:0]       r_sat, g_sat, b_sat;
  logic             load_pix;

  logic [DIM_W-1:0]   col_inc, row_inc;
  logic [ALIGN_W-1:0] pad_len;
  logic               row_end, last_row;

  sat8 #(.W(PIX_W)) u_sat_r (.d(in_r), .q(r_sat));
  sat8 #(.W(PIX_W)) u_sat_g (.d(in_g), .q(g_sat));
  sat8 #(.W(PIX_W)) u_sat_b (.d(in_b), .q(b_sat));

  // Pad bytes per row = (4 - 3w mod 4) mod 4, which reduces to w mod 4.
  assign pad_len  = width_q[ALIGN_W-1:0];
  assign col_inc  = col_q + DIM_W'(1);
  assign row_inc  = row_q + DIM_W'(1);
  assign row_end  = (col_inc == width_q);
  assign last_row = (row_inc == height_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      pad_q    <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      pad_q    <= pad_d;
      if (load_pix) begin
        r_q <= r_sat;
        g_q <= g_sat;
        b_q <= b_sat;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    col_d     = col_q;
    row_d     = row_q;
    pad_d     = pad_q;
    load_pix  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((width == '0) || (height == '0)) begin
            err = 1'b1;
          end else begin
            width_d  = width;
            height_d = height;
            col_d    = '0;
            row_d    = '0;
            state_d  = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          load_pix = 1'b1;
          state_d  = ST_EMIT_B;
        end
      end

      ST_EMIT_B: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = b_q;
        if (out_ready) state_d = ST_EMIT_G;
      end

      ST_EMIT_G: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = g_q;
        if (out_ready) state_d = ST_EMIT_R;
      end

      ST_EMIT_R: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_q;
        out_last  = row_end && last_row && (pad_len == '0);
        if (out_ready) begin
          col_d = col_inc;
          if (!row_end) begin
            state_d = ST_LOAD;
          end else if (pad_len != '0) begin
            pad_d   = ALIGN_W'(1);
            state_d = ST_PAD;
          end else begin
            col_d   = '0;
            row_d   = row_inc;
            state_d = last_row ? ST_FIN : ST_LOAD;
          end
        end
      end

      ST_PAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (pad_q == pad_len) && last_row;
        if (out_ready) begin
          if (pad_q == pad_len) begin
            col_d   = '0;
            row_d   = row_inc;
            state_d = last_row ? ST_FIN : ST_LOAD;
          end else begin
            pad_d = pad_q + ALIGN_W'(1);
          end
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
